// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and helpers for the uart_tx channel arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    // Width of a channel index; never below one bit so a grant register always exists.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with count-based full/empty flags
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push_ok;
    logic              pop_ok;

    // Flags derive from the registered count only, so a same-cycle pop never frees a slot.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin N-channel byte arbiter with message lock in front of uart_tx
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             ch_wr,
    input  logic [NUM_CH*DATA_W-1:0]      ch_din,
    input  logic [NUM_CH-1:0]             ch_lock,
    output logic [NUM_CH-1:0]             ch_ready,
    output logic [NUM_CH-1:0]             ch_overflow,
    input  logic                          ovf_clr,
    output logic                          uart_wr,
    output logic [DATA_W-1:0]             uart_din,
    input  logic                          uart_ready,
    output logic [ch_idx_w(NUM_CH)-1:0]   grant_id
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    arb_state_t        state;
    logic [CH_W-1:0]   rr_ptr;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_pop;
    logic [DATA_W-1:0] fifo_dout [NUM_CH];
    logic              pick_valid;
    logic [CH_W-1:0]   pick_sel;

    // Rotate the request vector by ptr and take the first set bit, wrapping at NUM_CH.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   ptr);
        logic [CH_W:0]   idx;
        logic            found;
        logic [CH_W-1:0] sel;
        found = 1'b0;
        sel   = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = {1'b0, ptr} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(NUM_CH)) begin
                idx = idx - (CH_W+1)'(NUM_CH);
            end
            if (!found && req[idx[CH_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[CH_W-1:0];
            end
        end
        return {found, sel};
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
        sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .resetn (reset),
            .push   (ch_wr[i] && !fifo_full[i]),
            .pop    (fifo_pop[i]),
            .din    (ch_din[i*DATA_W +: DATA_W]),
            .dout   (fifo_dout[i]),
            .full   (fifo_full[i]),
            .empty  (fifo_empty[i])
        );
    end

    assign ch_ready = ~fifo_full;

    // A locked channel keeps the grant even while its FIFO is empty.
    always_comb begin
        pick_valid = 1'b0;
        pick_sel   = grant_id;
        if (ch_lock[grant_id]) begin
            pick_valid = !fifo_empty[grant_id];
        end else begin
            {pick_valid, pick_sel} = rr_pick(~fifo_empty, rr_ptr);
        end
    end

    always_comb begin
        fifo_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fifo_pop[i] = (state == IDLE) && uart_ready && pick_valid && (pick_sel == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ch_overflow <= '0;
        end else if (ovf_clr) begin
            ch_overflow <= '0;
        end else begin
            ch_overflow <= ch_overflow | (ch_wr & fifo_full);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            uart_wr  <= 1'b0;
            uart_din <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (uart_ready && pick_valid) begin
                        grant_id <= pick_sel;
                        uart_din <= fifo_dout[pick_sel];
                        uart_wr  <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    uart_wr <= 1'b0;
                    rr_ptr  <= (grant_id == CH_W'(NUM_CH-1)) ? '0 : grant_id + CH_W'(1);
                    state   <= HOLD;
                end
                // One dead cycle lets uart_tx drop uart_ready before the next decision.
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    uart_wr <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ch_wr;
    logic [31:0] ch_din;
    logic [3:0]  ch_lock;
    logic [3:0]  ch_ready;
    logic [3:0]  ch_overflow;
    logic        ovf_clr;
    logic        uart_wr;
    logic [7:0]  uart_din;
    logic        uart_ready;
    logic [1:0]  grant_id;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0;
    int tfall;
    logic [7:0] got_b [$];
    int         got_c [$];

    uart_tx_arbiter #(
        .NUM_CH     (4),
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_wr       (ch_wr),
        .ch_din      (ch_din),
        .ch_lock     (ch_lock),
        .ch_ready    (ch_ready),
        .ch_overflow (ch_overflow),
        .ovf_clr     (ovf_clr),
        .uart_wr     (uart_wr),
        .uart_din    (uart_din),
        .uart_ready  (uart_ready),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uart_wr === 1'b1) begin
            got_b.push_back(uart_din);
            got_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] qb(input int i);
        return (i < got_b.size()) ? 32'(got_b[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] qc(input int i);
        return (i < got_c.size()) ? 32'(got_c[i]) : 32'hFFFF;
    endfunction

    task automatic apply_reset();
        reset      = 1'b0;
        ch_wr      = '0;
        ch_din     = '0;
        ch_lock    = '0;
        ovf_clr    = 1'b0;
        uart_ready = 1'b0;
        tick(2);
        reset = 1'b1;
        got_b.delete();
        got_c.delete();
    endtask

    initial begin
        // Reset held with all write strobes active
        reset      = 1'b0;
        ch_wr      = 4'hF;
        ch_din     = 32'hDEADBEEF;
        ch_lock    = '0;
        ovf_clr    = 1'b0;
        uart_ready = 1'b1;
        tick(3);
        reset = 1'b1;
        ch_wr = '0;
        check("rst_ready", ch_ready, 4'hF);
        check("rst_wr", uart_wr, 1'b0);
        check("rst_ovf", ch_overflow, 4'h0);
        check("rst_din", uart_din, 8'h00);
        check("rst_grant", grant_id, 2'd0);
        tick(4);
        check("rst_no_emit", got_b.size(), 0);

        // Round-robin across ch0, ch2, ch3
        apply_reset();
        uart_ready = 1'b1;
        ch_din = {8'h44, 8'h43, 8'h00, 8'h41};
        ch_wr  = 4'b1101;
        t0 = cyc;
        tick(1);
        ch_wr = '0;
        tick(15);
        check("rr_count", got_b.size(), 3);
        check("rr_b0", qb(0), 8'h41);
        check("rr_b1", qb(1), 8'h43);
        check("rr_b2", qb(2), 8'h44);
        check("rr_latency", qc(0) - t0, 2);
        check("rr_gap01", qc(1) - qc(0), 3);
        check("rr_gap12", qc(2) - qc(1), 3);
        check("rr_din_hold", uart_din, 8'h44);
        check("rr_grant", grant_id, 2'd3);

        // Lock: ch1 message "OX" is not interleaved with ch0
        apply_reset();
        uart_ready = 1'b1;
        ch_lock = 4'b0010;
        ch_din[15:8] = 8'h4F;
        ch_wr = 4'b0010;
        tick(1);
        ch_wr = '0;
        tick(1);
        ch_din[7:0] = 8'h30;
        ch_wr = 4'b0001;
        tick(1);
        ch_wr = '0;
        tick(3);
        ch_din[15:8] = 8'h58;
        ch_wr = 4'b0010;
        tick(1);
        ch_wr = '0;
        tick(6);
        check("lock_held_count", got_b.size(), 2);
        ch_lock = '0;
        tfall = cyc;
        tick(8);
        check("lock_count", got_b.size(), 3);
        check("lock_b0", qb(0), 8'h4F);
        check("lock_b1", qb(1), 8'h58);
        check("lock_b2", qb(2), 8'h30);
        check("lock_after_fall", qc(2) > tfall, 1'b1);
        check("lock_grant", grant_id, 2'd0);

        // Overflow on ch2 with the UART stalled
        apply_reset();
        uart_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ch_din[23:16] = 8'hA0 + 8'(i);
            ch_wr = 4'b0100;
            tick(1);
        end
        ch_wr = '0;
        check("ovf_full_ready", ch_ready, 4'b1011);
        check("ovf_not_yet", ch_overflow, 4'h0);
        ch_din[23:16] = 8'hA4;
        ch_wr = 4'b0100;
        tick(1);
        ch_wr = '0;
        check("ovf_set", ch_overflow, 4'b0100);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", ch_overflow, 4'h0);
        ch_wr   = 4'b0100;
        ovf_clr = 1'b1;
        tick(1);
        ch_wr   = '0;
        ovf_clr = 1'b0;
        check("ovf_clr_prio", ch_overflow, 4'h0);
        uart_ready = 1'b1;
        tick(16);
        check("ovf_count", got_b.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_b%0d", i), qb(i), 8'hA0 + 8'(i));
        end
        check("ovf_drained", ch_ready, 4'hF);

        // Backpressure: nothing leaves while uart_ready is low
        apply_reset();
        uart_ready = 1'b0;
        ch_din[31:24] = 8'h55;
        ch_wr = 4'b1000;
        tick(1);
        ch_din[31:24] = 8'h66;
        tick(1);
        ch_wr = '0;
        tick(20);
        check("bp_none", got_b.size(), 0);
        check("bp_wr_low", uart_wr, 1'b0);
        uart_ready = 1'b1;
        t0 = cyc;
        tick(10);
        check("bp_first_lat", qc(0) - t0, 1);
        check("bp_b0", qb(0), 8'h55);
        check("bp_b1", qb(1), 8'h66);

        // Reset asserted during the SEND cycle
        apply_reset();
        uart_ready = 1'b1;
        ch_din[15:8] = 8'h11;
        ch_wr = 4'b0010;
        tick(1);
        ch_din[15:8] = 8'h22;
        tick(1);
        ch_din[15:8] = 8'h33;
        check("mid_send", uart_wr, 1'b1);
        reset = 1'b0;
        tick(1);
        ch_wr = '0;
        check("mid_wr_low", uart_wr, 1'b0);
        tick(1);
        reset = 1'b1;
        got_b.delete();
        got_c.delete();
        tick(15);
        check("mid_none", got_b.size(), 0);
        check("mid_ready", ch_ready, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
